// File: rtl/mem_lsu.sv
// Load/store unit between the MEM stage and a byte-addressed data memory.
// Converts byte/half/word loads and stores into aligned word accesses, with read-modify-write for sub-word stores.
module mem_lsu #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_write_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_unsigned_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  input  logic [4:0]        req_rd_i,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic [DATA_W-1:0] resp_data_o,
  output logic [4:0]        resp_rd_o,
  output logic              resp_err_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              mem_write_o,
  output logic              mem_read_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam int unsigned TAG_W = 5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_RESP
  } state_e;

  state_e            state_q, state_d;
  logic              write_q, write_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [TAG_W-1:0]  rd_q, rd_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic              misalign_c;
  logic [1:0]        lane_c;
  logic [ADDR_W-1:0] aligned_c;
  logic [7:0]        ld_byte_c;
  logic [15:0]       ld_half_c;
  logic [DATA_W-1:0] ld_data_c;
  logic [DATA_W-1:0] st_data_c;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      write_q <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Size 11 is reserved and always reported as an error.
  always_comb begin
    case (req_size_i)
      2'b00:   misalign_c = 1'b0;
      2'b01:   misalign_c = req_addr_i[0];
      2'b10:   misalign_c = (req_addr_i[1:0] != 2'b00);
      default: misalign_c = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    write_d = write_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rd_d    = rd_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          write_d = req_write_i;
          size_d  = req_size_i;
          uns_d   = req_unsigned_i;
          addr_d  = req_addr_i;
          wdata_d = req_wdata_i;
          rd_d    = req_rd_i;
          err_d   = misalign_c;
          if (misalign_c) begin
            state_d = S_RESP;
          end else if (!req_write_i || (req_size_i != 2'b10)) begin
            state_d = S_RD;
          end else begin
            state_d = S_WR;
          end
        end
      end
      S_RD: begin
        rdata_d = mem_rdata_i;
        state_d = write_q ? S_WR : S_RESP;
      end
      S_WR: begin
        state_d = S_RESP;
      end
      S_RESP: begin
        if (resp_ready_i) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign lane_c    = addr_q[1:0];
  assign aligned_c = {addr_q[ADDR_W-1:2], 2'b00};
  assign ld_byte_c = rdata_q[{lane_c, 3'b000} +: 8];
  assign ld_half_c = rdata_q[{lane_c[1], 4'b0000} +: 16];

  // Load extraction and extension from the captured word.
  always_comb begin
    case (size_q)
      2'b00:   ld_data_c = uns_q ? {{(DATA_W-8){1'b0}}, ld_byte_c}
                                 : {{(DATA_W-8){ld_byte_c[7]}}, ld_byte_c};
      2'b01:   ld_data_c = uns_q ? {{(DATA_W-16){1'b0}}, ld_half_c}
                                 : {{(DATA_W-16){ld_half_c[15]}}, ld_half_c};
      default: ld_data_c = rdata_q;
    endcase
  end

  // Sub-word stores merge the new lane into the word read in RD.
  always_comb begin
    st_data_c = rdata_q;
    case (size_q)
      2'b00:   st_data_c[{lane_c, 3'b000} +: 8]     = wdata_q[7:0];
      2'b01:   st_data_c[{lane_c[1], 4'b0000} +: 16] = wdata_q[15:0];
      default: st_data_c = wdata_q;
    endcase
  end

  assign req_ready_o  = (state_q == S_IDLE);
  assign mem_read_o   = (state_q == S_RD);
  assign mem_write_o  = (state_q == S_WR);
  assign mem_addr_o   = (mem_read_o || mem_write_o) ? aligned_c : '0;
  assign mem_wdata_o  = mem_write_o ? st_data_c : '0;
  assign resp_valid_o = (state_q == S_RESP);
  assign resp_err_o   = resp_valid_o && err_q;
  assign resp_rd_o    = resp_valid_o ? rd_q : '0;
  assign resp_data_o  = (resp_valid_o && !err_q && !write_q) ? ld_data_c : '0;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu against a 32-byte little-endian memory model.
module tb_mem_lsu;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_valid_i, req_ready_o, req_write_i, req_unsigned_i;
  logic [1:0]  req_size_i;
  logic [31:0] req_addr_i, req_wdata_i;
  logic [4:0]  req_rd_i, resp_rd_o;
  logic        resp_valid_o, resp_ready_i, resp_err_o;
  logic [31:0] resp_data_o, mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic        mem_write_o, mem_read_o;

  int vectors = 0;
  int miscompares = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  int both_cnt = 0;
  logic [31:0] last_wdata = 32'h0;

  logic [7:0] mem [32] = '{default: 8'h00};

  mem_lsu #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_write_i(req_write_i), .req_size_i(req_size_i),
    .req_unsigned_i(req_unsigned_i), .req_addr_i(req_addr_i),
    .req_wdata_i(req_wdata_i), .req_rd_i(req_rd_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
    .resp_data_o(resp_data_o), .resp_rd_o(resp_rd_o), .resp_err_o(resp_err_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_write_o(mem_write_o), .mem_read_o(mem_read_o),
    .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  // Combinational little-endian read, 4-byte write on the rising edge.
  always_comb begin
    logic [4:0] a;
    a = mem_addr_o[4:0];
    mem_rdata_i = {mem[5'(a + 5'd3)], mem[5'(a + 5'd2)], mem[5'(a + 5'd1)], mem[a]};
  end

  always @(posedge clk_i) begin
    if (mem_write_o) begin
      for (int k = 0; k < 4; k++) begin
        mem[5'(mem_addr_o[4:0] + 5'(k))] <= mem_wdata_o[8*k +: 8];
      end
    end
  end

  always @(negedge clk_i) begin
    if (mem_read_o) rd_cnt++;
    if (mem_write_o) begin
      wr_cnt++;
      last_wdata = mem_wdata_o;
    end
    if (mem_read_o && mem_write_o) both_cnt++;
  end

  function automatic logic [31:0] peek(input logic [4:0] a);
    return {mem[5'(a + 5'd3)], mem[5'(a + 5'd2)], mem[5'(a + 5'd1)], mem[a]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  int          t_lat, t_rd, t_wr, t_both;
  logic [31:0] t_data;
  logic        t_err;
  logic [4:0]  t_tag;

  // Issue one request, wait for the response (bounded), then complete the handshake.
  task automatic txn(input logic w, input logic [1:0] sz, input logic u,
                     input logic [31:0] a, input logic [31:0] wd, input logic [4:0] tag);
    int r0, w0, b0;
    @(negedge clk_i);
    r0 = rd_cnt; w0 = wr_cnt; b0 = both_cnt;
    req_valid_i = 1'b1; req_write_i = w; req_size_i = sz; req_unsigned_i = u;
    req_addr_i = a; req_wdata_i = wd; req_rd_i = tag;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    t_lat = 1;
    while (!resp_valid_o && t_lat < 8) begin
      @(negedge clk_i);
      t_lat++;
    end
    t_data = resp_data_o; t_err = resp_err_o; t_tag = resp_rd_o;
    t_rd = rd_cnt - r0; t_wr = wr_cnt - w0; t_both = both_cnt - b0;
    resp_ready_i = 1'b1;
    @(negedge clk_i);
    resp_ready_i = 1'b0;
  endtask

  initial begin
    req_valid_i = 1'b0; req_write_i = 1'b0; req_size_i = 2'b00; req_unsigned_i = 1'b0;
    req_addr_i = 32'h0; req_wdata_i = 32'h0; req_rd_i = 5'd0; resp_ready_i = 1'b0;
    rst_i = 1'b1;
    #1 rst_i = 1'b0;
    #2;
    chk("rst_ready", 32'(req_ready_o), 32'd1);
    chk("rst_ctl", {26'd0, resp_valid_o, resp_err_o, mem_write_o, mem_read_o, 2'b00}, 32'd0);
    chk("rst_data", resp_data_o | mem_addr_o | mem_wdata_o | 32'(resp_rd_o), 32'd0);
    #1 rst_i = 1'b1;

    // SW then LW of a full word
    txn(1'b1, 2'b10, 1'b0, 32'd4, 32'h8899AABB, 5'd3);
    chk("sw_lat", 32'(t_lat), 32'd2);
    chk("sw_resp", {t_data[30:0], t_err}, 32'd0);
    chk("sw_tag", 32'(t_tag), 32'd3);
    chk("sw_strobes", 32'(t_rd * 16 + t_wr), 32'd1);
    chk("sw_mem", peek(5'd4), 32'h8899AABB);
    txn(1'b0, 2'b10, 1'b0, 32'd4, 32'h0, 5'd7);
    chk("lw_data", t_data, 32'h8899AABB);
    chk("lw_lat_err_tag", {t_lat[7:0], 7'd0, t_err, 11'd0, t_tag}, {8'd2, 7'd0, 1'b0, 11'd0, 5'd7});

    // Sub-word loads with sign and zero extension
    txn(1'b0, 2'b00, 1'b0, 32'd5, 32'h0, 5'd1);
    chk("lb", t_data, 32'hFFFFFFAA);
    txn(1'b0, 2'b00, 1'b1, 32'd5, 32'h0, 5'd2);
    chk("lbu", t_data, 32'h000000AA);
    txn(1'b0, 2'b01, 1'b0, 32'd6, 32'h0, 5'd4);
    chk("lh", t_data, 32'hFFFF8899);
    txn(1'b0, 2'b01, 1'b1, 32'd6, 32'h0, 5'd5);
    chk("lhu", t_data, 32'h00008899);
    chk("lhu_lat", 32'(t_lat), 32'd2);

    // Read-modify-write stores
    txn(1'b1, 2'b00, 1'b0, 32'd6, 32'hDEADBE11, 5'd9);
    chk("sb_wdata", last_wdata, 32'h8811AABB);
    chk("sb_lat", 32'(t_lat), 32'd3);
    chk("sb_strobes", 32'(t_rd * 16 + t_wr), 32'h11);
    txn(1'b1, 2'b01, 1'b0, 32'd4, 32'hFFFF2233, 5'd10);
    chk("sh_lat", 32'(t_lat), 32'd3);
    chk("sh_mem", peek(5'd4), 32'h88112233);
    txn(1'b0, 2'b10, 1'b0, 32'd4, 32'h0, 5'd11);
    chk("lw_after_sh", t_data, 32'h88112233);

    // Misaligned and reserved-size requests
    txn(1'b0, 2'b10, 1'b0, 32'd2, 32'h0, 5'd12);
    chk("lw2_err", {t_data[30:0], t_err}, 32'd1);
    chk("lw2_lat_strobe", 32'(t_lat * 256 + t_rd + t_wr), 32'd256);
    txn(1'b0, 2'b01, 1'b0, 32'd7, 32'h0, 5'd13);
    chk("lh7_err", {t_data[30:0], t_err}, 32'd1);
    chk("lh7_lat_strobe_tag", 32'(t_lat * 256 + (t_rd + t_wr) * 64 + 32'(t_tag)), 32'd269);
    txn(1'b1, 2'b11, 1'b0, 32'd0, 32'h12345678, 5'd14);
    chk("sz11_err", {t_data[30:0], t_err}, 32'd1);
    chk("sz11_lat_strobe", 32'(t_lat * 256 + t_rd + t_wr), 32'd256);
    chk("sz11_mem", peek(5'd0), 32'd0);
    chk("never_both", 32'(both_cnt), 32'd0);

    // Backpressure: response must hold while resp_ready_i is low
    @(negedge clk_i);
    req_valid_i = 1'b1; req_write_i = 1'b0; req_size_i = 2'b10; req_unsigned_i = 1'b0;
    req_addr_i = 32'd4; req_rd_i = 5'd21;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    t_lat = 1;
    while (!resp_valid_o && t_lat < 8) begin
      @(negedge clk_i);
      t_lat++;
    end
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold", {resp_valid_o, req_ready_o, resp_err_o, resp_rd_o, 24'd0}, {1'b1, 1'b0, 1'b0, 5'd21, 24'd0});
      chk("bp_data", resp_data_o, 32'h88112233);
      @(negedge clk_i);
    end
    resp_ready_i = 1'b1;
    @(negedge clk_i);
    resp_ready_i = 1'b0;
    chk("bp_release", {30'd0, req_ready_o, resp_valid_o}, 32'd2);

    // Reset during the write phase of an SB aborts the store
    @(negedge clk_i);
    req_valid_i = 1'b1; req_write_i = 1'b1; req_size_i = 2'b00; req_unsigned_i = 1'b0;
    req_addr_i = 32'd6; req_wdata_i = 32'h00000055; req_rd_i = 5'd22;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    @(negedge clk_i);
    chk("abort_in_wr", {mem_write_o, mem_wdata_o[30:0]}, {1'b1, 31'h08552233});
    #2 rst_i = 1'b0;
    #1;
    chk("abort_strobe", {29'd0, mem_write_o, mem_read_o, req_ready_o}, 32'd1);
    @(negedge clk_i);
    rst_i = 1'b1;
    chk("abort_mem", peek(5'd4), 32'h88112233);
    txn(1'b0, 2'b10, 1'b0, 32'd4, 32'h0, 5'd23);
    chk("abort_lw", t_data, 32'h88112233);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
